// File: rtl/gsim_row_sched.sv
// Row-fetch scheduler for the Gauss-Seidel solver: issues matrix-memory reads with
// FIFO credits and presents tagged 256-bit rows to the compute core.
module gsim_row_sched #(
   parameter int DEPTH = 4,
   parameter int ITERS = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [4:0]   i_matrix_num,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_mem_rreq,
   output logic [9:0]   o_mem_addr,
   input  logic         i_mem_rrdy,
   input  logic [255:0] i_mem_dout,
   input  logic         i_mem_dout_vld,
   output logic         o_row_vld,
   output logic [255:0] o_row_data,
   output logic [4:0]   o_row_idx,
   output logic [4:0]   o_row_mat,
   output logic [3:0]   o_row_iter,
   output logic         o_row_last,
   input  logic         i_row_rdy,
   output logic         o_err
);
   // state | meaning
   // IDLE  | waiting for i_start
   // ISSUE | issuing row reads under FIFO credit
   // DRAIN | all reads issued, waiting for FIFO and in-flight to empty
   // DONE  | one-cycle o_done pulse

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [3:0]  ITER_LAST = 4'(ITERS - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [4:0] mat;
      logic [3:0] iter;
      logic [4:0] row;
   } pos_t;

   localparam pos_t POS_START = '{mat: 5'd0, iter: 4'd0, row: 5'd16};

   // b row (16) first, then rows 0..15 for each iteration, then next matrix
   function automatic pos_t pos_next(input pos_t p);
      pos_t n;
      n = p;
      if (p.row == 5'd16) begin
         n.row = 5'd0;
      end else if (p.row == 5'd15) begin
         if (p.iter == ITER_LAST) begin
            n.row  = 5'd16;
            n.iter = 4'd0;
            n.mat  = p.mat + 5'd1;
         end else begin
            n.row  = 5'd0;
            n.iter = p.iter + 4'd1;
         end
      end else begin
         n.row = p.row + 5'd1;
      end
      return n;
   endfunction

   state_t         state, state_nxt;
   logic [4:0]     mat_num;
   pos_t           iss_pos, pop_pos;
   logic [255:0]   fifo_mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  fifo_count, inflight;
   logic [CW-1:0]  count_nxt, inflight_nxt;
   logic [CW:0]    occupancy;
   logic           accept, push, pop_fire, iss_last;

   assign occupancy = (CW + 1)'(fifo_count) + (CW + 1)'(inflight);
   assign accept    = o_mem_rreq && i_mem_rrdy;
   assign push      = i_mem_dout_vld && (inflight != '0);
   assign pop_fire  = o_row_vld && i_row_rdy;
   assign iss_last  = (iss_pos.row == 5'd15) && (iss_pos.iter == ITER_LAST) &&
                      (iss_pos.mat == mat_num - 5'd1);

   assign count_nxt    = fifo_count + CW'(push) - CW'(pop_fire);
   assign inflight_nxt = inflight + CW'(accept) - CW'(push);

   always_comb begin
      state_nxt  = state;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      o_mem_rreq = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) state_nxt = (i_matrix_num == 5'd0) ? DONE : ISSUE;
         end
         ISSUE: begin
            o_busy     = 1'b1;
            o_mem_rreq = (occupancy < DEPTH_C);
            if (accept && iss_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            o_busy = 1'b1;
            // look at next-cycle occupancy so o_done lands one cycle after the final pop
            if (count_nxt == '0 && inflight_nxt == '0) state_nxt = DONE;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         mat_num    <= '0;
         iss_pos    <= '0;
         pop_pos    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         inflight   <= '0;
         o_err      <= 1'b0;
      end else begin
         state      <= state_nxt;
         fifo_count <= count_nxt;
         inflight   <= inflight_nxt;
         if (state == IDLE && i_start) begin
            mat_num <= i_matrix_num;
            iss_pos <= POS_START;
            pop_pos <= POS_START;
         end else begin
            if (accept)   iss_pos <= pos_next(iss_pos);
            if (pop_fire) pop_pos <= pos_next(pop_pos);
         end
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
         if (i_mem_dout_vld && inflight == '0) o_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      end else if (push) begin
         fifo_mem[wr_ptr] <= i_mem_dout;
      end
   end

   assign o_mem_addr = (10'(iss_pos.mat) * 10'd17) + 10'(iss_pos.row);
   assign o_row_vld  = (fifo_count != '0);
   assign o_row_data = fifo_mem[rd_ptr];
   assign o_row_idx  = pop_pos.row;
   assign o_row_mat  = pop_pos.mat;
   assign o_row_iter = pop_pos.iter;
   assign o_row_last = (pop_pos.row == 5'd15) && (pop_pos.iter == ITER_LAST);

endmodule

// File: tb/tb_gsim_row_sched.sv
// Randomized bench for gsim_row_sched: a queue-based memory and row-order reference
// model check every output each cycle, plus directed reset, stall and stray-data cases.
module tb_gsim_row_sched;
   localparam int DEPTH = 4;
   localparam int ITERS = 16;

   logic         i_clk = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_start = 1'b0;
   logic [4:0]   i_matrix_num = '0;
   logic         o_busy, o_done, o_mem_rreq;
   logic [9:0]   o_mem_addr;
   logic         i_mem_rrdy = 1'b0;
   logic [255:0] i_mem_dout = '0;
   logic         i_mem_dout_vld = 1'b0;
   logic         o_row_vld;
   logic [255:0] o_row_data;
   logic [4:0]   o_row_idx, o_row_mat;
   logic [3:0]   o_row_iter;
   logic         o_row_last;
   logic         i_row_rdy = 1'b0;
   logic         o_err;

   int tests = 0;
   int fails = 0;

   gsim_row_sched #(.DEPTH(DEPTH), .ITERS(ITERS)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_matrix_num(i_matrix_num),
      .o_busy(o_busy), .o_done(o_done), .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr),
      .i_mem_rrdy(i_mem_rrdy), .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
      .o_row_vld(o_row_vld), .o_row_data(o_row_data), .o_row_idx(o_row_idx),
      .o_row_mat(o_row_mat), .o_row_iter(o_row_iter), .o_row_last(o_row_last),
      .i_row_rdy(i_row_rdy), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int           due;
      logic [255:0] d;
   } pend_t;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_rreq"}, o_mem_rreq, 0);
      check({tag, "_addr"}, o_mem_addr, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_vld"},  o_row_vld, 0);
      check({tag, "_data"}, o_row_data, 0);
      check({tag, "_idx"},  o_row_idx, 0);
      check({tag, "_mat"},  o_row_mat, 0);
      check({tag, "_iter"}, o_row_iter, 0);
      check({tag, "_last"}, o_row_last, 0);
      check({tag, "_err"},  o_err, 0);
   endtask

   // rrdy_mode/rdy_mode: 0 always 1, 1 toggling 1010, 2 random
   task automatic run(input int n, input int lat_lo, input int lat_hi, input int rrdy_mode,
                      input int rdy_mode, input int stall_at, input int reset_at,
                      output int dur);
      int e_addr[$], e_idx[$], e_mat[$], e_iter[$], e_last[$];
      pend_t pend[$];
      logic [255:0] fifoq[$];
      int total, issued, popped, cyc, last_due, stall_left, lat;
      bit busy_m, done_m, stalled, saw_done, exp_rreq, acc, pop, dvld;
      pend_t p;

      for (int m = 0; m < n; m++) begin
         e_addr.push_back(m * 17 + 16); e_idx.push_back(16); e_mat.push_back(m);
         e_iter.push_back(0); e_last.push_back(0);
         for (int it = 0; it < ITERS; it++)
            for (int r = 0; r < 16; r++) begin
               e_addr.push_back(m * 17 + r); e_idx.push_back(r); e_mat.push_back(m);
               e_iter.push_back(it); e_last.push_back((r == 15 && it == ITERS - 1) ? 1 : 0);
            end
      end
      total = e_addr.size();
      issued = 0; popped = 0; cyc = 0; last_due = -1; stall_left = 0;
      busy_m = 0; done_m = 0; stalled = 0; saw_done = 0; dur = -1;

      while (!saw_done && cyc < 4000) begin
         @(negedge i_clk);
         if (reset_at >= 0 && issued == reset_at) begin
            i_reset = 1'b1; i_start = 1'b0; i_mem_dout_vld = 1'b0;
            #1;
            check_zero_outputs("midrun_reset");
            @(negedge i_clk);
            i_reset = 1'b0;
            return;
         end
         i_start = (cyc == 0);
         i_matrix_num = 5'(n);
         i_mem_rrdy = (rrdy_mode == 0) ? 1'b1 : (rrdy_mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
         if (stall_at >= 0 && !stalled && popped == stall_at) begin
            stalled = 1; stall_left = 20;
         end
         if (stall_left > 0) i_row_rdy = 1'b0;
         else i_row_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
         dvld = (pend.size() > 0) && (pend[0].due <= cyc);
         i_mem_dout_vld = dvld;
         i_mem_dout = dvld ? pend[0].d : 256'(0);

         exp_rreq = busy_m && (issued < total) && (pend.size() + fifoq.size() < DEPTH);
         check("rreq", o_mem_rreq, exp_rreq);
         if (exp_rreq) check("addr", o_mem_addr, e_addr[issued]);
         check("row_vld", o_row_vld, fifoq.size() != 0);
         if (fifoq.size() != 0) begin
            check("row_data", o_row_data, fifoq[0]);
            check("row_idx",  o_row_idx,  e_idx[popped]);
            check("row_mat",  o_row_mat,  e_mat[popped]);
            check("row_iter", o_row_iter, e_iter[popped]);
            check("row_last", o_row_last, e_last[popped]);
         end
         check("busy", o_busy, busy_m);
         check("done", o_done, done_m);
         check("err", o_err, 0);
         if (stall_left == 1) begin
            check("stall_rreq_low", o_mem_rreq, 0);
            check("stall_fifo_full_vld", o_row_vld, 1);
         end
         if (done_m) begin
            saw_done = 1;
            dur = cyc;
            i_start = 1'b0;
            i_mem_dout_vld = 1'b0;
            break;
         end

         acc = exp_rreq && i_mem_rrdy;
         pop = (fifoq.size() != 0) && i_row_rdy;
         @(posedge i_clk);
         if (pop) begin
            void'(fifoq.pop_front());
            popped++;
         end
         if (dvld) begin
            p = pend.pop_front();
            fifoq.push_back(p.d);
         end
         if (acc) begin
            lat = $urandom_range(lat_hi, lat_lo);
            p.due = cyc + lat;
            if (p.due <= last_due) p.due = last_due + 1;
            last_due = p.due;
            p.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pend.push_back(p);
            issued++;
         end
         done_m = 0;
         if (cyc == 0) begin
            if (n == 0) done_m = 1;
            else busy_m = 1;
         end
         if (pop && popped == total) begin
            done_m = 1;
            busy_m = 0;
         end
         if (stall_left > 0) stall_left--;
         cyc++;
      end
      check("run_done_seen", saw_done, 1);
      check("run_all_issued", issued, total);
      check("run_all_popped", popped, total);
   endtask

   initial begin
      int dur;
      #1;
      check_zero_outputs("por");
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;

      // one matrix, latency 1, no back-pressure: full rate, done 257+3 cycles after start
      run(1, 1, 1, 0, 0, -1, -1, dur);
      check("t1_done_cycle", dur, 260);

      run(2, 3, 3, 0, 0, -1, -1, dur);
      run(1, 1, 4, 0, 0, 40, -1, dur);
      run(1, 1, 3, 1, 2, -1, -1, dur);

      run(0, 1, 1, 0, 0, -1, -1, dur);
      check("n0_done_cycle", dur, 1);

      run(2, 1, 5, 2, 2, 100, -1, dur);

      // reset during matrix 0, iteration 5, then a clean rerun
      run(1, 1, 3, 2, 2, -1, 1 + 16 * 5 + 3, dur);
      run(1, 1, 2, 2, 0, -1, -1, dur);
      check("rerun_done_cycle_set", dur > 0, 1);

      // stray read data with nothing in flight
      @(negedge i_clk);
      i_mem_dout = {8{32'hdead_beef}};
      i_mem_dout_vld = 1'b1;
      @(negedge i_clk);
      i_mem_dout_vld = 1'b0;
      check("stray_err_set", o_err, 1);
      check("stray_dropped", o_row_vld, 0);
      @(negedge i_clk);
      check("stray_err_sticky", o_err, 1);
      i_reset = 1'b1;
      #1;
      check("reset_clears_err", o_err, 0);
      @(negedge i_clk);
      i_reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
